jtag_tap_sync: RTL

Synchronous JTAG test access port (TAP), the target-side counterpart of the team's `jtag_master` bench driver. It oversamples the external TCK/TMS/TDI pins with the system clock and runs the IEEE 1149.1 16-state TAP controller. It provides a 5-bit instruction register, an IDCODE register, a BYPASS register, and one 32-bit USER data register with a capture/update handshake to the SoC. It sits at the chip boundary between the JTAG pins and the debug/user logic.

---
 rtl/jtag_tap_pkg.sv | 46 ++++
 rtl/jtag_pin_sync.sv | 39 +++
 rtl/jtag_tap_sync.sv | 164 ++++++++++++++++
 3 files changed

// File: rtl/jtag_tap_pkg.sv
// Shared types and constants for the synchronous JTAG TAP.
// Covers TAP states, instruction codes and data-register selection.
package jtag_tap_pkg;

   localparam int unsigned IrLen = 5;

   localparam logic [IrLen-1:0] InstrIdcode = 5'h01;
   localparam logic [IrLen-1:0] InstrUser   = 5'h11;
   localparam logic [IrLen-1:0] InstrBypass = 5'h1F;
   localparam logic [IrLen-1:0] IrCapture   = 5'b00001;

   typedef enum logic [3:0] {
      TLR,
      RTI,
      SelDR,
      CapDR,
      ShDR,
      Ex1DR,
      PauseDR,
      Ex2DR,
      UpdDR,
      SelIR,
      CapIR,
      ShIR,
      Ex1IR,
      PauseIR,
      Ex2IR,
      UpdIR
   } tap_state_e;

   typedef enum logic [1:0] {
      DrIdcode,
      DrBypass,
      DrUser
   } dr_sel_e;

   // Unknown instruction codes fall back to BYPASS.
   function automatic dr_sel_e decode_ir(input logic [IrLen-1:0] ir);
      case (ir)
         InstrIdcode: return DrIdcode;
         InstrUser:   return DrUser;
         default:     return DrBypass;
      endcase
   endfunction

endpackage

// File: rtl/jtag_pin_sync.sv
// Two-flop synchronizers for TCK/TMS/TDI plus TCK edge detection.
// Edge strobes are single clk-cycle pulses derived from the synchronized TCK.
module jtag_pin_sync (
   input  logic i_clk,
   input  logic i_rst_n,
   input  logic i_tck,
   input  logic i_tms,
   input  logic i_tdi,
   output logic o_tck_rise,
   output logic o_tck_fall,
   output logic o_tms,
   output logic o_tdi
);

   logic [1:0] r_tck_sync;
   logic [1:0] r_tms_sync;
   logic [1:0] r_tdi_sync;
   logic       r_tck_prev;

   always_ff @(posedge i_clk) begin
      if (!i_rst_n) begin
         r_tck_sync <= '0;
         r_tms_sync <= '0;
         r_tdi_sync <= '0;
         r_tck_prev <= 1'b0;
      end else begin
         r_tck_sync <= {r_tck_sync[0], i_tck};
         r_tms_sync <= {r_tms_sync[0], i_tms};
         r_tdi_sync <= {r_tdi_sync[0], i_tdi};
         r_tck_prev <= r_tck_sync[1];
      end
   end

   assign o_tck_rise = r_tck_sync[1] & ~r_tck_prev;
   assign o_tck_fall = ~r_tck_sync[1] & r_tck_prev;
   assign o_tms      = r_tms_sync[1];
   assign o_tdi      = r_tdi_sync[1];

endmodule

// File: rtl/jtag_tap_sync.sv
// Oversampled IEEE 1149.1 TAP: 16-state controller, 5-bit IR, IDCODE,
// BYPASS and a 32-bit USER data register with an update strobe to the SoC.
module jtag_tap_sync
   import jtag_tap_pkg::*;
#(
   parameter logic [31:0] IdCode = 32'h0000_0000
) (
   input  logic        clk_i,
   input  logic        rst_ni,
   input  logic        tck_i,
   input  logic        tms_i,
   input  logic        tdi_i,
   output logic        tdo_o,
   output logic        tdo_oe_o,
   input  logic [31:0] user_capture_data_i,
   output logic        user_update_o,
   output logic [31:0] user_update_data_o
);

   logic w_tck_rise;
   logic w_tck_fall;
   logic w_tms;
   logic w_tdi;

   tap_state_e r_state;
   tap_state_e w_state_next;

   logic [IrLen-1:0] r_ir;
   logic [IrLen-1:0] r_ir_sr;
   logic [31:0]      r_idcode_sr;
   logic             r_bypass_sr;
   logic [31:0]      r_user_sr;

   logic             r_tdo;
   logic             r_tdo_oe;
   logic             r_user_update;
   logic [31:0]      r_user_data;

   dr_sel_e w_dr_sel;
   logic    w_in_shift;
   logic    w_shift_lsb;

   jtag_pin_sync u_pin_sync (
      .i_clk      (clk_i),
      .i_rst_n    (rst_ni),
      .i_tck      (tck_i),
      .i_tms      (tms_i),
      .i_tdi      (tdi_i),
      .o_tck_rise (w_tck_rise),
      .o_tck_fall (w_tck_fall),
      .o_tms      (w_tms),
      .o_tdi      (w_tdi)
   );

   always_ff @(posedge clk_i) begin
      if (!rst_ni) begin
         r_state <= TLR;
      end else begin
         r_state <= w_state_next;
      end
   end

   always_comb begin
      w_state_next = r_state;
      if (w_tck_rise) begin
         case (r_state)
            TLR:     w_state_next = w_tms ? TLR     : RTI;
            RTI:     w_state_next = w_tms ? SelDR   : RTI;
            SelDR:   w_state_next = w_tms ? SelIR   : CapDR;
            CapDR:   w_state_next = w_tms ? Ex1DR   : ShDR;
            ShDR:    w_state_next = w_tms ? Ex1DR   : ShDR;
            Ex1DR:   w_state_next = w_tms ? UpdDR   : PauseDR;
            PauseDR: w_state_next = w_tms ? Ex2DR   : PauseDR;
            Ex2DR:   w_state_next = w_tms ? UpdDR   : ShDR;
            UpdDR:   w_state_next = w_tms ? SelDR   : RTI;
            SelIR:   w_state_next = w_tms ? TLR     : CapIR;
            CapIR:   w_state_next = w_tms ? Ex1IR   : ShIR;
            ShIR:    w_state_next = w_tms ? Ex1IR   : ShIR;
            Ex1IR:   w_state_next = w_tms ? UpdIR   : PauseIR;
            PauseIR: w_state_next = w_tms ? Ex2IR   : PauseIR;
            Ex2IR:   w_state_next = w_tms ? UpdIR   : ShIR;
            UpdIR:   w_state_next = w_tms ? SelDR   : RTI;
            default: w_state_next = TLR;
         endcase
      end
   end

   assign w_dr_sel   = decode_ir(r_ir);
   assign w_in_shift = (r_state == ShDR) || (r_state == ShIR);

   always_comb begin
      w_shift_lsb = 1'b0;
      if (r_state == ShIR) begin
         w_shift_lsb = r_ir_sr[0];
      end else if (r_state == ShDR) begin
         case (w_dr_sel)
            DrIdcode: w_shift_lsb = r_idcode_sr[0];
            DrUser:   w_shift_lsb = r_user_sr[0];
            default:  w_shift_lsb = r_bypass_sr;
         endcase
      end
   end

   // Shifting/capture on TCK rise; TDO and register updates on TCK fall.
   always_ff @(posedge clk_i) begin
      if (!rst_ni) begin
         r_ir          <= InstrIdcode;
         r_ir_sr       <= '0;
         r_idcode_sr   <= '0;
         r_bypass_sr   <= 1'b0;
         r_user_sr     <= '0;
         r_tdo         <= 1'b0;
         r_tdo_oe      <= 1'b0;
         r_user_update <= 1'b0;
         r_user_data   <= '0;
      end else begin
         r_user_update <= 1'b0;

         if (r_state == TLR) begin
            r_ir <= InstrIdcode;
         end

         if (w_tck_rise) begin
            case (r_state)
               CapIR: r_ir_sr <= IrCapture;
               ShIR:  r_ir_sr <= {w_tdi, r_ir_sr[IrLen-1:1]};
               CapDR: begin
                  case (w_dr_sel)
                     DrIdcode: r_idcode_sr <= IdCode;
                     DrUser:   r_user_sr   <= user_capture_data_i;
                     default:  r_bypass_sr <= 1'b0;
                  endcase
               end
               ShDR: begin
                  case (w_dr_sel)
                     DrIdcode: r_idcode_sr <= {w_tdi, r_idcode_sr[31:1]};
                     DrUser:   r_user_sr   <= {w_tdi, r_user_sr[31:1]};
                     default:  r_bypass_sr <= w_tdi;
                  endcase
               end
               default: ;
            endcase
         end

         if (w_tck_fall) begin
            r_tdo    <= w_shift_lsb;
            r_tdo_oe <= w_in_shift;
            if (r_state == UpdIR) begin
               r_ir <= r_ir_sr;
            end
            if ((r_state == UpdDR) && (w_dr_sel == DrUser)) begin
               r_user_update <= 1'b1;
               r_user_data   <= r_user_sr;
            end
         end
      end
   end

   assign tdo_o              = r_tdo;
   assign tdo_oe_o           = r_tdo_oe;
   assign user_update_o      = r_user_update;
   assign user_update_data_o = r_user_data;

endmodule
